gcd_bus_controller: RTL and testbench

Sequencing controller for the group's single-bus datapath, computing GCD(A,B) by repeated subtraction. Registers A, B and OUT share the bus. The block captures two operands from the switch bank, one per `go` press. It then drives the ALU function code, tristate enables and load strobes for each compare and subtract step. It reports `done` with the result in OUT, or `err` on zero operands or a watchdog overflow.

---
 rtl/gcd_ctrl_pkg.sv | 36 +++
 rtl/go_sync_edge.sv | 40 ++++
 rtl/gcd_bus_controller.sv | 156 +++++++++++++++
 tb/tb_gcd_bus_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gcd_ctrl_pkg
// Purpose  : Shared definitions for the GCD single-bus sequencing controller:
//            controller state encoding, ALU function codes and the default
//            width of the subtraction-iteration counter.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package gcd_ctrl_pkg;

  // Default iteration-counter width; watchdog trips at 2^W-1 subtractions.
  localparam int ITER_W_DEFAULT = 8;

  // ALU function codes understood by the datapath.
  localparam logic [2:0] F_NOP   = 3'd0;
  localparam logic [2:0] F_PASSA = 3'd2;
  localparam logic [2:0] F_SUBAB = 3'd4;
  localparam logic [2:0] F_SUBBA = 3'd5;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    WAIT_A = 4'd1,
    LD_A   = 4'd2,
    WAIT_B = 4'd3,
    LD_B   = 4'd4,
    CMP    = 4'd5,
    SUB_A  = 4'd6,
    SUB_B  = 4'd7,
    FIN    = 4'd8,
    DONE   = 4'd9,
    ERR    = 4'd10
  } state_t;

endpackage : gcd_ctrl_pkg
`default_nettype wire

// File: rtl/go_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : go_sync_edge
// Purpose  : Brings an asynchronous push-button into the clk domain through a
//            two-flop synchronizer and turns each rising edge into a single
//            one-cycle pulse, however long the button is held.
// Ports    : clk      - system clock, rising edge
//            rst_n    - asynchronous active-low reset
//            async_in - raw button level, asynchronous to clk
//            pulse    - one-cycle pulse per synchronized rising edge
// Revision : 1.0  initial release
// ============================================================================
module go_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= async_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Rising edge of the synchronized level only; r_sync1 may be metastable.
  assign pulse = r_sync2 & ~r_prev;

endmodule : go_sync_edge
`default_nettype wire

// File: rtl/gcd_bus_controller.sv
`default_nettype none
// ============================================================================
// Module   : gcd_bus_controller
// Purpose  : Sequencing controller for the single-bus GCD datapath. Captures
//            operands A and B from the switch bank (one go press each after
//            an initial go), then alternates compare and subtract steps until
//            A == B, loading the result into OUT. Terminates with err on a
//            zero operand or when the iteration watchdog expires.
// Ports    : clk, rst_n          - clock, async active-low reset
//            go                  - raw push button (asynchronous)
//            az, bz, zf, bf      - datapath status flags
//            f                   - ALU function code
//            tsw, talu           - bus drivers: switch bank, ALU
//            lda, ldb, ldout     - register load strobes
//            tout                - OUT drives the display
//            busy, done, err     - status
// Revision : 1.0  initial release
// ============================================================================
module gcd_bus_controller
  import gcd_ctrl_pkg::*;
#(
  parameter int ITER_W = ITER_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       az,
  input  logic       bz,
  input  logic       zf,
  input  logic       bf,
  output logic [2:0] f,
  output logic       tsw,
  output logic       talu,
  output logic       lda,
  output logic       ldb,
  output logic       ldout,
  output logic       tout,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [ITER_W-1:0] c_iter_max = '1;

  state_t            r_state;
  state_t            w_next;
  logic [ITER_W-1:0] r_iter;
  logic              w_go_p;

  go_sync_edge u_go_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (go),
    .pulse    (w_go_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The CMP check keeps the counter from ever reaching a subtraction at
  // c_iter_max; the guard below only makes the no-wrap property local.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter <= '0;
    end else if (r_state == LD_B) begin
      r_iter <= '0;
    end else if ((r_state == SUB_A || r_state == SUB_B) && r_iter != c_iter_max) begin
      r_iter <= r_iter + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (w_go_p) w_next = WAIT_A;
      WAIT_A: if (w_go_p) w_next = LD_A;
      LD_A:   w_next = WAIT_B;
      WAIT_B: if (w_go_p) w_next = LD_B;
      LD_B:   w_next = CMP;
      CMP: begin
        if (az || bz)                w_next = ERR;
        else if (zf)                 w_next = FIN;
        else if (r_iter == c_iter_max) w_next = ERR;
        else if (bf)                 w_next = SUB_B;
        else                         w_next = SUB_A;
      end
      SUB_A:  w_next = CMP;
      SUB_B:  w_next = CMP;
      FIN:    w_next = DONE;
      DONE:   if (w_go_p) w_next = IDLE;
      ERR:    if (w_go_p) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Moore output decode; tsw and talu are never set in the same state.
  always_comb begin
    f     = F_NOP;
    tsw   = 1'b0;
    talu  = 1'b0;
    lda   = 1'b0;
    ldb   = 1'b0;
    ldout = 1'b0;
    tout  = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    err   = 1'b0;
    unique case (r_state)
      WAIT_A: tsw = 1'b1;
      LD_A: begin
        tsw = 1'b1;
        lda = 1'b1;
      end
      WAIT_B: tsw = 1'b1;
      LD_B: begin
        tsw = 1'b1;
        ldb = 1'b1;
      end
      CMP: begin
        f    = F_SUBAB;
        busy = 1'b1;
      end
      SUB_A: begin
        f    = F_SUBAB;
        talu = 1'b1;
        lda  = 1'b1;
        busy = 1'b1;
      end
      SUB_B: begin
        f    = F_SUBBA;
        talu = 1'b1;
        ldb  = 1'b1;
        busy = 1'b1;
      end
      FIN: begin
        f     = F_PASSA;
        talu  = 1'b1;
        ldout = 1'b1;
        busy  = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        tout = 1'b1;
      end
      ERR:    err = 1'b1;
      default: ;
    endcase
  end

endmodule : gcd_bus_controller
`default_nettype wire

// File: tb/tb_gcd_bus_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_bus_controller
// Purpose  : Self-checking bench. Two controllers (ITER_W = 8 and 4) share the
//            go button and switch bank; each drives its own behavioural
//            single-bus datapath. Results are compared against a plain
//            arithmetic GCD-by-subtraction reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_gcd_bus_controller;
  import gcd_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic [7:0] sw = 8'h00;

  logic [1:0] az_s, bz_s, zf_s, bf_s;
  logic [2:0] f_s [2];
  logic [1:0] tsw_s, talu_s, lda_s, ldb_s, ldout_s, tout_s, busy_s, done_s, err_s;

  logic [7:0] ra [2];
  logic [7:0] rb [2];
  logic [7:0] ro [2];
  logic [7:0] alu_r [2];
  logic [7:0] bus [2];

  int wv [2] = '{8, 4};

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int conflicts = 0;

  bit started [2];
  bit ended [2];
  int t0 [2];
  int tend [2];
  int nsub [2];
  int nld [2];

  always #5 clk = ~clk;

  gcd_bus_controller #(.ITER_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .go(go),
    .az(az_s[0]), .bz(bz_s[0]), .zf(zf_s[0]), .bf(bf_s[0]),
    .f(f_s[0]), .tsw(tsw_s[0]), .talu(talu_s[0]), .lda(lda_s[0]), .ldb(ldb_s[0]),
    .ldout(ldout_s[0]), .tout(tout_s[0]), .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0])
  );

  gcd_bus_controller #(.ITER_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .go(go),
    .az(az_s[1]), .bz(bz_s[1]), .zf(zf_s[1]), .bf(bf_s[1]),
    .f(f_s[1]), .tsw(tsw_s[1]), .talu(talu_s[1]), .lda(lda_s[1]), .ldb(ldb_s[1]),
    .ldout(ldout_s[1]), .tout(tout_s[1]), .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1])
  );

  // Behavioural datapath: ALU, shared bus, flags.
  always_comb begin
    az_s = '0;
    bz_s = '0;
    zf_s = '0;
    bf_s = '0;
    for (int i = 0; i < 2; i++) begin
      alu_r[i] = 8'h00;
      case (f_s[i])
        F_SUBAB: begin alu_r[i] = ra[i] - rb[i]; bf_s[i] = (ra[i] < rb[i]); end
        F_SUBBA: begin alu_r[i] = rb[i] - ra[i]; bf_s[i] = (rb[i] < ra[i]); end
        F_PASSA: alu_r[i] = ra[i];
        default: alu_r[i] = 8'h00;
      endcase
      zf_s[i] = (alu_r[i] == 8'h00);
      az_s[i] = (ra[i] == 8'h00);
      bz_s[i] = (rb[i] == 8'h00);
      bus[i]  = tsw_s[i] ? sw : (talu_s[i] ? alu_r[i] : 8'h00);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (lda_s[i])   ra[i] <= bus[i];
      if (ldb_s[i])   rb[i] <= bus[i];
      if (ldout_s[i]) ro[i] <= bus[i];
    end
  end

  // Activity monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tsw_s[i] && talu_s[i]) conflicts++;
      if (busy_s[i] && !started[i]) begin started[i] = 1'b1; t0[i] = cyc; end
      if (talu_s[i] && (lda_s[i] || ldb_s[i])) nsub[i]++;
      if (ldout_s[i]) nld[i]++;
      if ((done_s[i] || err_s[i]) && !ended[i]) begin ended[i] = 1'b1; tend[i] = cyc; end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: Euclid by repeated subtraction with a watchdog of 2^w-1 steps.
  function automatic void ref_gcd(input int a, input int b, input int w,
                                  output bit ok, output int s, output int res);
    int lim;
    lim = (1 << w) - 1;
    ok = 1'b0; s = 0; res = 0;
    if (a == 0 || b == 0) return;
    while (a != b) begin
      if (s == lim) return;
      if (a < b) b = b - a;
      else       a = a - b;
      s++;
    end
    ok = 1'b1;
    res = a;
  endfunction

  function automatic logic [11:0] outs(input int i);
    return {f_s[i], tsw_s[i], talu_s[i], lda_s[i], ldb_s[i], ldout_s[i],
            tout_s[i], busy_s[i], done_s[i], err_s[i]};
  endfunction

  task automatic press();
    @(negedge clk); go = 1'b1;
    repeat (4) @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic arm();
    for (int i = 0; i < 2; i++) begin
      started[i] = 1'b0; ended[i] = 1'b0;
      t0[i] = 0; tend[i] = 0; nsub[i] = 0; nld[i] = 0;
    end
  endtask

  task automatic run_op(input int a, input int b, input bit back_to_idle);
    bit ok;
    int s, res, n;
    sw = a[7:0];
    press();            // IDLE -> WAIT_A
    press();            // WAIT_A -> LD_A -> WAIT_B
    sw = b[7:0];
    arm();
    press();            // WAIT_B -> LD_B -> CMP ...
    n = 0;
    while (!(ended[0] && ended[1]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!(ended[0] && ended[1])) check($sformatf("run_timeout a=%0d b=%0d", a, b), 0, 1);
    for (int i = 0; i < 2; i++) begin
      ref_gcd(a, b, wv[i], ok, s, res);
      check($sformatf("done w=%0d a=%0d b=%0d", wv[i], a, b), int'(done_s[i]), int'(ok));
      check($sformatf("err w=%0d a=%0d b=%0d", wv[i], a, b), int'(err_s[i]), int'(!ok));
      check($sformatf("subs w=%0d a=%0d b=%0d", wv[i], a, b), nsub[i], s);
      check($sformatf("ldout_cnt w=%0d a=%0d b=%0d", wv[i], a, b), nld[i], ok ? 1 : 0);
      check($sformatf("latency w=%0d a=%0d b=%0d", wv[i], a, b), tend[i] - t0[i],
            ok ? 2 * s + 2 : 2 * s + 1);
      if (ok) check($sformatf("out w=%0d a=%0d b=%0d", wv[i], a, b), int'(ro[i]), res);
    end
    if (back_to_idle) press();
  endtask

  initial begin
    int n, tswcnt;
    // Outputs must be 0 while reset is held.
    #1;
    check("reset_outs_w8", int'(outs(0)), 0);
    check("reset_outs_w4", int'(outs(1)), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outs_w8", int'(outs(0)), 0);
    check("idle_outs_w4", int'(outs(1)), 0);

    run_op(12, 18, 1'b1);
    run_op(255, 1, 1'b1);
    run_op(200, 1, 1'b1);
    run_op(0, 7, 1'b1);
    run_op(7, 0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      run_op($urandom_range(1, 255), $urandom_range(1, 255), 1'b1);
    end

    // Asynchronous reset while the wide controller is in SUB_A.
    sw = 8'd200; press(); press();
    sw = 8'd1; arm();
    @(negedge clk); go = 1'b1;
    n = 0;
    while (!(talu_s[0] && lda_s[0]) && n < 50) begin @(negedge clk); n++; end
    check("reach_sub_a", int'(talu_s[0] && lda_s[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outs_w8", int'(outs(0)), 0);
    check("midreset_outs_w4", int'(outs(1)), 0);
    @(negedge clk); go = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle_w8", int'(outs(0)), 0);
    run_op(9, 6, 1'b1);

    // go held high in DONE: one return to IDLE, never on to WAIT_A.
    run_op(12, 18, 1'b0);
    @(negedge clk); go = 1'b1;
    tswcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tswcnt += int'(tsw_s[0]) + int'(tsw_s[1]);
    end
    go = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_go_tsw_cycles", tswcnt, 0);
    check("hold_go_idle_w8", int'(outs(0)), 0);
    check("hold_go_idle_w4", int'(outs(1)), 0);
    run_op(18, 12, 1'b1);

    check("bus_excl_conflicts", conflicts, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gcd_bus_controller
`default_nettype wire
